// File: rtl/perceptron_layer_seq.sv
// Layer sequencer for one shared pipelined perceptron.
// Each cycle in ISSUE reads one weight row. A token pipeline follows that row
// through the memory read and the perceptron latency, and it steers the
// perceptron output into the matching y_out slot.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; y_out holds the last layer result
// ISSUE  | one weight-row read per cycle, rows 0..M-1
// DRAIN  | all rows issued, waiting for the last token to retire
// DONE   | single-cycle completion pulse
module perceptron_layer_seq #(
  parameter  int N          = 4,
  parameter  int M          = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int LATENCY    = 3,
  localparam int AW         = (M > 1) ? $clog2(M) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [N*DATA_WIDTH-1:0] x_in,
  output logic                    busy,
  output logic                    w_rd_en,
  output logic [AW-1:0]           w_addr,
  input  logic [N*DATA_WIDTH-1:0] w_data,
  input  logic [DATA_WIDTH-1:0]   b_data,
  output logic [N*DATA_WIDTH-1:0] p_x,
  output logic [N*DATA_WIDTH-1:0] p_w,
  output logic [DATA_WIDTH-1:0]   p_b,
  input  logic [DATA_WIDTH-1:0]   p_y,
  output logic [M*DATA_WIDTH-1:0] y_out,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(M - 1);

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic                           w_accept;
  logic                           w_drain_empty;
  logic [AW-1:0]                  r_issue_cnt;
  logic [N*DATA_WIDTH-1:0]        r_x;
  logic [M-1:0][DATA_WIDTH-1:0]   r_y;
  // Stage 0 is the row just issued; stage LATENCY is the row whose result is on p_y.
  logic [LATENCY:0]               r_tok_vld;
  logic [LATENCY:0][AW-1:0]       r_tok_idx;

  // Only the oldest stage may still be occupied when the last result is due.
  assign w_drain_empty = ~|r_tok_vld[LATENCY-1:0];

  assign p_x   = r_x;
  assign p_w   = w_data;
  assign p_b   = b_data;
  assign y_out = r_y;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs. Abort suppresses reads and the done pulse.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    w_rd_en     = 1'b0;
    w_addr      = '0;
    done        = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_rd_en = 1'b1;
          w_addr  = r_issue_cnt;
          if (r_issue_cnt == LAST_ROW) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_drain_empty) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = !abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Input latch, row counter, token pipeline and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_issue_cnt <= '0;
      r_tok_vld   <= '0;
      r_tok_idx   <= '0;
    end else begin
      if (w_accept) begin
        r_x         <= x_in;
        r_issue_cnt <= '0;
      end else if (abort) begin
        r_issue_cnt <= '0;
      end else if (w_rd_en) begin
        r_issue_cnt <= (r_issue_cnt == LAST_ROW) ? '0 : r_issue_cnt + 1'b1;
      end

      if (abort) begin
        r_tok_vld <= '0;
        r_tok_idx <= '0;
      end else begin
        r_tok_vld <= {r_tok_vld[LATENCY-1:0], w_rd_en};
        r_tok_idx <= {r_tok_idx[LATENCY-1:0], r_issue_cnt};
        if (r_tok_vld[LATENCY]) begin
          r_y[r_tok_idx[LATENCY]] <= p_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_layer_seq.sv
// Bench for perceptron_layer_seq: a synchronous weight memory, a 3-deep
// perceptron stub and a layer-level reference model.
module tb_perceptron_layer_seq;

  localparam int N   = 4;
  localparam int M   = 4;
  localparam int DW  = 8;
  localparam int LAT = 3;
  localparam int AW  = 2;
  localparam int DONE_CYC = M + 2 + LAT;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic [N*DW-1:0] x_in;
  logic            busy;
  logic            w_rd_en;
  logic [AW-1:0]   w_addr;
  logic [N*DW-1:0] w_data;
  logic [DW-1:0]   b_data;
  logic [N*DW-1:0] p_x;
  logic [N*DW-1:0] p_w;
  logic [DW-1:0]   p_b;
  logic [DW-1:0]   p_y;
  logic [M*DW-1:0] y_out;
  logic            done;

  always #5 clk = ~clk;

  perceptron_layer_seq #(.N(N), .M(M), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .x_in(x_in),
    .busy(busy), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .b_data(b_data), .p_x(p_x), .p_w(p_w), .p_b(p_b), .p_y(p_y),
    .y_out(y_out), .done(done)
  );

  logic [N*DW-1:0] mem_w [M];
  logic [DW-1:0]   mem_b [M];
  logic [DW-1:0]   s1, s2, s3;
  logic [M*DW-1:0] model_y;
  int              n_checks = 0;
  int              n_errors = 0;

  // Neuron function: signed dot product plus bias, truncated to DW bits.
  function automatic logic [DW-1:0] neuron(input logic [N*DW-1:0] xv,
                                           input logic [N*DW-1:0] wv,
                                           input logic [DW-1:0] bv);
    int acc;
    acc = int'($signed(bv));
    for (int i = 0; i < N; i++)
      acc += int'($signed(xv[i*DW +: DW])) * int'($signed(wv[i*DW +: DW]));
    return acc[DW-1:0];
  endfunction

  // Synchronous weight memory: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (w_rd_en) begin
      w_data <= mem_w[w_addr];
      b_data <= mem_b[w_addr];
    end
  end

  // Perceptron stub: y valid LAT edges after x/w/b are applied.
  always @(posedge clk) begin
    s1 <= neuron(p_x, p_w, p_b);
    s2 <= s1;
    s3 <= s2;
  end
  assign p_y = s3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_basic();
    for (int k = 0; k < M; k++) begin
      mem_w[k] = {N{8'(k)}};
      mem_b[k] = 8'd1;
    end
  endtask

  task automatic load_random();
    for (int k = 0; k < M; k++) begin
      mem_w[k] = $urandom;
      mem_b[k] = 8'($urandom_range(255));
    end
  endtask

  // Runs one layer starting in cycle 0 and checks every cycle up to the end.
  // abort_cyc / rst_cyc (0 = unused) assert abort or rst for that one cycle.
  task automatic run_layer(input logic [N*DW-1:0] xv, input bit hold,
                           input int abort_cyc, input int rst_cyc);
    logic [M*DW-1:0] new_y;
    logic [M*DW-1:0] old_y;
    logic [M*DW-1:0] exp_y;
    bit              normal;
    bit              exp_rd;
    int              stop;
    int              last;
    for (int k = 0; k < M; k++) new_y[k*DW +: DW] = neuron(xv, mem_w[k], mem_b[k]);
    old_y  = model_y;
    exp_y  = old_y;
    normal = (abort_cyc == 0) && (rst_cyc == 0);
    stop   = (abort_cyc != 0) ? abort_cyc : (rst_cyc != 0) ? rst_cyc : 1000;
    last   = normal ? DONE_CYC : DONE_CYC + 3;
    @(posedge clk); #1;
    x_in  = xv;
    start = 1'b1;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        x_in  = $urandom;
        abort = (c == abort_cyc);
        rst   = (c == rst_cyc);
      end
      @(negedge clk);
      check("busy", busy, (c >= 1) && (c <= (normal ? DONE_CYC : stop)));
      check("done", done, normal && (c == DONE_CYC));
      exp_rd = (c >= 1) && (c <= M) && (c <= stop);
      if (c != abort_cyc) check("w_rd_en", w_rd_en, exp_rd);
      if (exp_rd && c != abort_cyc) check("w_addr", w_addr, c - 1);
      if (rst_cyc != 0 && c > rst_cyc) begin
        exp_y = '0;
      end else begin
        for (int k = 0; k < M; k++)
          exp_y[k*DW +: DW] = ((k + 1 + LAT + 1 < c) && (k + 1 + LAT + 1 < stop)) ?
                              new_y[k*DW +: DW] : old_y[k*DW +: DW];
      end
      check("y_out", y_out, exp_y);
      if (c == 2) check("p_x", p_x, xv);
      if (rst_cyc != 0 && c == rst_cyc + 1) check("p_x_rst", p_x, 0);
    end
    abort   = 1'b0;
    rst     = 1'b0;
    model_y = exp_y;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    x_in    = '0;
    model_y = '0;
    load_basic();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", w_rd_en, 0);
    check("rst_addr", w_addr, 0);
    check("rst_done", done, 0);
    check("rst_y", y_out, 0);
    check("rst_px", p_x, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic layer: x all ones, row k weights all k, bias 1.
    load_basic();
    run_layer({N{8'd1}}, 1'b0, 0, 0);
    check("basic_y", y_out, 32'h0D090501);

    // Negative values: x={-2,3,-1,4}, w={1,-1,2,1}, b=-3 gives -6 per neuron.
    for (int k = 0; k < M; k++) begin
      mem_w[k] = {8'd1, 8'd2, 8'hFF, 8'd1};
      mem_b[k] = 8'hFD;
    end
    run_layer({8'd4, 8'hFF, 8'd3, 8'hFE}, 1'b0, 0, 0);
    check("neg_y", y_out, 32'hFAFAFAFA);

    // start held across two back-to-back layers; x_in scrambled mid-layer.
    load_basic();
    run_layer({N{8'd1}}, 1'b1, 0, 0);
    run_layer({N{8'd2}}, 1'b0, 0, 0);
    check("held_y", y_out, 32'h19110901);

    // Abort in cycle 3, then a clean random layer.
    load_random();
    run_layer($urandom, 1'b0, 3, 0);
    check("abort_keep_y", y_out, 32'h19110901);
    load_random();
    run_layer($urandom, 1'b0, 0, 0);

    // Reset in cycle 6 (DRAIN), then a clean random layer.
    load_random();
    run_layer($urandom, 1'b0, 0, 6);
    load_random();
    run_layer($urandom, 1'b0, 0, 0);

    // Additional random layers.
    for (int t = 0; t < 4; t++) begin
      load_random();
      run_layer($urandom, 1'b0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
